// File: rtl/csa_adder_pkg.sv
// Shared constants for the FrodoKEM wide modular adder: default geometry,
// security-level encodings, modulus masks and CSA tree sizing helpers.
package csa_adder_pkg;

  localparam int DEF_T     = 64;
  localparam int DEF_WIDTH = 16;

  localparam logic [2:0] SEC_LEV_640  = 3'd1;
  localparam logic [2:0] SEC_LEV_976  = 3'd2;
  localparam logic [2:0] SEC_LEV_1344 = 3'd3;

  localparam logic [15:0] MASK_Q15 = 16'h7FFF;
  localparam logic [15:0] MASK_Q16 = 16'hFFFF;

  typedef enum logic {
    MODE_RED = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

  // Only Frodo-640 uses q = 2^15; every other code falls back to q = 2^16.
  function automatic logic [15:0] q_mask(input logic [2:0] sec_lev);
    logic [15:0] m;
    case (sec_lev)
      SEC_LEV_640:               m = MASK_Q15;
      SEC_LEV_976, SEC_LEV_1344: m = MASK_Q16;
      default:                   m = MASK_Q16;
    endcase
    return m;
  endfunction

  // Operand count after one layer of 3:2 compressors; leftovers pass through.
  function automatic int csa_next_count(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

endpackage

// File: rtl/csa_adder_csa_3to2.sv
// WIDTH-bit 3:2 carry-save compressor. The carry out of the top bit is
// dropped, which keeps every layer exact modulo 2^WIDTH.
module csa_3to2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/csa_adder.sv
// Wide modular adder: reduction (T lanes + scalar via CSA tree + CPA) or
// element-wise vector add, masked to q. Optional macro: CSA_ADD_PIPE_EN.
module csa_adder
  import csa_adder_pkg::*;
#(
  parameter int T     = DEF_T,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [2:0]         i_sec_lev,
  input  logic               i_mode,
  input  logic [T*WIDTH-1:0] i_array,
  input  logic [WIDTH-1:0]   i_element,
  input  logic [T*WIDTH-1:0] i_a,
  input  logic [T*WIDTH-1:0] i_b,
  output logic [WIDTH-1:0]   o_element,
  output logic [T*WIDTH-1:0] o_array
);

  localparam int N0 = T + 1;

  function automatic int cnt_at(input int layer);
    int n;
    n = N0;
    for (int i = 0; i < layer; i++) n = csa_next_count(n);
    return n;
  endfunction

  function automatic int num_layers();
    int n;
    int l;
    n = N0;
    l = 0;
    while (n > 2) begin
      n = csa_next_count(n);
      l++;
    end
    return l;
  endfunction

  localparam int LAYERS = num_layers();

  // No handshake: every cycle's inputs are consumed; mode/sec_lev travel with the data.
  mode_e            mode_now;
  logic [WIDTH-1:0] mask_now;

  assign mode_now = mode_e'(i_mode);
  assign mask_now = WIDTH'(q_mask(i_sec_lev));

  // Layer 0 holds the T+1 raw operands; each later layer compresses the previous one.
  for (genvar l = 0; l <= LAYERS; l++) begin : g_layer
    localparam int N = cnt_at(l);
    logic [WIDTH-1:0] v [N];

    if (l == 0) begin : g_in
      for (genvar k = 0; k < T; k++) begin : g_op
        assign v[k] = i_array[k*WIDTH +: WIDTH];
      end
      assign v[T] = i_element;
    end else begin : g_csa
      localparam int NP = cnt_at(l - 1);
      localparam int G  = NP / 3;
      localparam int R  = NP % 3;

      for (genvar g = 0; g < G; g++) begin : g_grp
        csa_3to2 #(.WIDTH(WIDTH)) u_csa (
          .a    (g_layer[l-1].v[3*g]),
          .b    (g_layer[l-1].v[3*g+1]),
          .c    (g_layer[l-1].v[3*g+2]),
          .sum  (v[2*g]),
          .carry(v[2*g+1])
        );
      end

      for (genvar r = 0; r < R; r++) begin : g_pass
        assign v[2*G+r] = g_layer[l-1].v[3*G+r];
      end
    end
  end

  logic [WIDTH-1:0] tree_sum;
  logic [WIDTH-1:0] tree_carry;

  assign tree_sum   = g_layer[LAYERS].v[0];
  assign tree_carry = g_layer[LAYERS].v[1];

  logic [WIDTH-1:0]   stage_sum;
  logic [WIDTH-1:0]   stage_carry;
  logic [T*WIDTH-1:0] stage_a;
  logic [T*WIDTH-1:0] stage_b;
  mode_e              stage_mode;
  logic [WIDTH-1:0]   stage_mask;

`ifdef CSA_ADD_PIPE_EN
  logic [WIDTH-1:0]   pipe_sum;
  logic [WIDTH-1:0]   pipe_carry;
  logic [T*WIDTH-1:0] pipe_a;
  logic [T*WIDTH-1:0] pipe_b;
  mode_e              pipe_mode;
  logic [WIDTH-1:0]   pipe_mask;

  // A zeroed stage decodes as a reduction of zero, matching the reset output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_sum   <= '0;
      pipe_carry <= '0;
      pipe_a     <= '0;
      pipe_b     <= '0;
      pipe_mode  <= MODE_RED;
      pipe_mask  <= '0;
    end else begin
      pipe_sum   <= tree_sum;
      pipe_carry <= tree_carry;
      pipe_a     <= i_a;
      pipe_b     <= i_b;
      pipe_mode  <= mode_now;
      pipe_mask  <= mask_now;
    end
  end

  assign stage_sum   = pipe_sum;
  assign stage_carry = pipe_carry;
  assign stage_a     = pipe_a;
  assign stage_b     = pipe_b;
  assign stage_mode  = pipe_mode;
  assign stage_mask  = pipe_mask;
`else
  assign stage_sum   = tree_sum;
  assign stage_carry = tree_carry;
  assign stage_a     = i_a;
  assign stage_b     = i_b;
  assign stage_mode  = mode_now;
  assign stage_mask  = mask_now;
`endif

  logic [WIDTH-1:0]   red_sum;
  logic [T*WIDTH-1:0] vec_sum;

  assign red_sum = (stage_sum + stage_carry) & stage_mask;

  for (genvar k = 0; k < T; k++) begin : g_vec
    assign vec_sum[k*WIDTH +: WIDTH] =
      (stage_a[k*WIDTH +: WIDTH] + stage_b[k*WIDTH +: WIDTH]) & stage_mask;
  end

  // The output belonging to the inactive mode keeps its previous value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_element <= '0;
      o_array   <= '0;
    end else if (stage_mode == MODE_RED) begin
      o_element <= red_sum;
    end else begin
      o_array   <= vec_sum;
    end
  end

endmodule

// File: tb/tb_csa_adder.sv
// Self-checking bench for csa_adder: directed steps, async reset checks and
// a randomized run against a behavioural sum model through an expected queue.
module tb_csa_adder;

  localparam int T = 64;
  localparam int W = 16;
`ifdef CSA_ADD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic [2:0]     i_sec_lev;
  logic           i_mode;
  logic [T*W-1:0] i_array;
  logic [W-1:0]   i_element;
  logic [T*W-1:0] i_a;
  logic [T*W-1:0] i_b;
  logic [W-1:0]   o_element;
  logic [T*W-1:0] o_array;

  csa_adder #(.T(T), .WIDTH(W)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_sec_lev(i_sec_lev),
    .i_mode   (i_mode),
    .i_array  (i_array),
    .i_element(i_element),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_element(o_element),
    .o_array  (o_array)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: each entry is {expected o_element, expected o_array}
  logic [T*W+W-1:0] exp_q[$];
  logic [W-1:0]     m_el;
  logic [T*W-1:0]   m_arr;

  function automatic logic [W-1:0] ref_mask(input logic [2:0] s);
    return (s == 3'd1) ? 16'h7FFF : 16'hFFFF;
  endfunction

  function automatic logic [T*W-1:0] fill_idx();
    logic [T*W-1:0] r;
    for (int k = 0; k < T; k++) r[k*W +: W] = W'(k);
    return r;
  endfunction

  function automatic logic [T*W-1:0] fill_const(input logic [W-1:0] v);
    logic [T*W-1:0] r;
    for (int k = 0; k < T; k++) r[k*W +: W] = v;
    return r;
  endfunction

  function automatic logic [T*W-1:0] fill_rand();
    logic [T*W-1:0] r;
    for (int k = 0; k < T; k++) r[k*W +: W] = W'($urandom_range(0, 65535));
    return r;
  endfunction

  task automatic check_out(input string tag, input logic [W-1:0] e_el,
                           input logic [T*W-1:0] e_arr);
    int bad;
    n_cmp++;
    assert (o_element === e_el) else begin
      n_err++;
      $display("FAIL %s element: got %h expected %h", tag, o_element, e_el);
      $error("%s element mismatch", tag);
    end
    n_cmp++;
    assert (o_array === e_arr) else begin
      n_err++;
      bad = 0;
      for (int k = T - 1; k >= 0; k--)
        if (o_array[k*W +: W] !== e_arr[k*W +: W]) bad = k;
      $display("FAIL %s array lane %0d: got %h expected %h", tag, bad,
               o_array[bad*W +: W], e_arr[bad*W +: W]);
      $error("%s array mismatch", tag);
    end
  endtask

  task automatic check_front(input string tag);
    logic [T*W+W-1:0] e;
    e = exp_q.pop_front();
    check_out(tag, e[T*W +: W], e[T*W-1:0]);
  endtask

  // Driver: apply one operation, update the model, compare once latency is covered.
  task automatic step(input string tag, input logic mode, input logic [2:0] sec,
                      input logic [T*W-1:0] arr, input logic [W-1:0] el,
                      input logic [T*W-1:0] a, input logic [T*W-1:0] b);
    logic [31:0]  s;
    logic [W:0]   t;
    logic [W-1:0] mask;
    i_mode    = mode;
    i_sec_lev = sec;
    i_array   = arr;
    i_element = el;
    i_a       = a;
    i_b       = b;
    mask = ref_mask(sec);
    if (mode == 1'b0) begin
      s = 32'(el);
      for (int k = 0; k < T; k++) s = s + 32'(arr[k*W +: W]);
      m_el = s[W-1:0] & mask;
    end else begin
      for (int k = 0; k < T; k++) begin
        t = {1'b0, a[k*W +: W]} + {1'b0, b[k*W +: W]};
        m_arr[k*W +: W] = t[W-1:0] & mask;
      end
    end
    exp_q.push_back({m_el, m_arr});
    @(posedge i_clk);
    #1;
    if (exp_q.size() >= LAT) check_front(tag);
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_mode    = 1'b1;
    i_sec_lev = 3'd3;
    i_array   = fill_rand();
    i_element = 16'hABCD;
    i_a       = fill_rand();
    i_b       = fill_rand();
    m_el      = '0;
    m_arr     = '0;

    // Reset held with live inputs
    repeat (3) begin
      @(posedge i_clk);
      #1;
      i_mode  = ~i_mode;
      i_array = fill_rand();
      i_a     = fill_rand();
    end
    check_out("reset_hold", '0, '0);
    i_rst_n = 1'b1;
    #2;
    check_out("post_release", '0, '0);

    // Directed patterns
    step("red_idx", 1'b0, 3'd1, fill_idx(), 16'd64, fill_rand(), fill_rand());
    step("vec_idx", 1'b1, 3'd1, fill_rand(), 16'h1234, fill_idx(), fill_idx());
    step("red_wrap_q16", 1'b0, 3'd3, fill_const(16'hFFFF), 16'hFFFF, fill_rand(), fill_rand());
    step("red_wrap_q15", 1'b0, 3'd1, fill_const(16'hFFFF), 16'hFFFF, fill_rand(), fill_rand());
    step("vec_wrap_q15", 1'b1, 3'd1, fill_rand(), 16'h0, fill_const(16'h8000), fill_const(16'h8001));
    step("vec_wrap_q16", 1'b1, 3'd3, fill_rand(), 16'h0, fill_const(16'h8000), fill_const(16'h8001));
    step("vec_half_q15", 1'b1, 3'd1, fill_rand(), 16'h0, fill_const(16'h4000), fill_const(16'h4000));
    step("vec_half_976", 1'b1, 3'd2, fill_rand(), 16'h0, fill_const(16'h4000), fill_const(16'h4000));
    step("red_zero_lev0", 1'b0, 3'd0, fill_const(16'h0), 16'h0, fill_rand(), fill_rand());
    step("red_lev7", 1'b0, 3'd7, fill_rand(), 16'h8001, fill_rand(), fill_rand());

    // Mid-run asynchronous reset
    step("pre_reset_red", 1'b0, 3'd2, fill_rand(), 16'h7777, fill_rand(), fill_rand());
    step("pre_reset_vec", 1'b1, 3'd2, fill_rand(), 16'h0, fill_rand(), fill_rand());
    #2;
    i_rst_n = 1'b0;
    #1;
    check_out("async_reset", '0, '0);
    exp_q.delete();
    m_el  = '0;
    m_arr = '0;
    @(posedge i_clk);
    #1;
    check_out("reset_clocked", '0, '0);
    i_rst_n = 1'b1;

    // Random run, mode toggled each cycle
    for (int i = 0; i < 10000; i++) begin
      step("random", 1'(i % 2), 3'($urandom_range(0, 7)), fill_rand(),
           W'($urandom_range(0, 65535)), fill_rand(), fill_rand());
    end

    // Drain any results still in flight
    while (exp_q.size() > 0) begin
      @(posedge i_clk);
      #1;
      check_front("drain");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
